// File: rtl/temporizador_pkg.sv
// Shared encodings for the countdown-timer control sequencer.
//   estado_t : 3-bit mode encoding driven out on modo
//   LED_*    : led_estado patterns for each adjust mode
//   led_de() : maps a mode to its led_estado pattern
package temporizador_pkg;

   typedef enum logic [2:0] {
      PARADO  = 3'b000,
      AJ_SEG  = 3'b001,
      AJ_MIN  = 3'b010,
      AJ_HORA = 3'b011,
      RODANDO = 3'b111,
      FIM     = 3'b100
   } estado_t;

   localparam logic [2:0] LED_APAGADO = 3'b000;
   localparam logic [2:0] LED_AJ_SEG  = 3'b001;
   localparam logic [2:0] LED_AJ_MIN  = 3'b011;
   localparam logic [2:0] LED_AJ_HORA = 3'b111;

   // Thermometer-style indicator of which field is being adjusted.
   function automatic logic [2:0] led_de(input estado_t e);
      case (e)
         AJ_SEG:  return LED_AJ_SEG;
         AJ_MIN:  return LED_AJ_MIN;
         AJ_HORA: return LED_AJ_HORA;
         default: return LED_APAGADO;
      endcase
   endfunction

endpackage

// File: rtl/filtro_botao.sv
// Push-button conditioner: 2-flop synchroniser, debounce, rising-edge pulse.
//   clk    : system clock
//   reset  : asynchronous, active-low
//   bruto  : raw asynchronous button level (active-high)
//   pulso  : registered 1-cycle pulse when the debounced level rises
module filtro_botao #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic bruto,
   output logic pulso
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sinc1;
   logic             sinc2;
   logic             estavel;
   logic [CNT_W-1:0] cont;

   // The count runs up to DEBOUNCE_CYCLES mismatches; the stable level and
   // the pulse are updated together on the edge that sees the full count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sinc1   <= 1'b0;
         sinc2   <= 1'b0;
         estavel <= 1'b0;
         cont    <= '0;
         pulso   <= 1'b0;
      end else begin
         sinc1 <= bruto;
         sinc2 <= sinc1;
         pulso <= 1'b0;
         if (sinc2 == estavel) begin
            cont <= '0;
         end else if (cont == CNT_W'(DEBOUNCE_CYCLES)) begin
            estavel <= sinc2;
            cont    <= '0;
            pulso   <= sinc2;
         end else begin
            cont <= cont + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/controle_cronometro.sv
// Mode sequencer for the countdown timer: conditions the three buttons,
// runs the stopped/adjust/running/expired FSM and the 1 Hz tick divider.
//   clk, reset                  : clock, asynchronous active-low reset
//   botao0/1/2                  : raw buttons (mode, increment, start/stop)
//   SW3                         : minute adjust selects tens when 1
//   zero                        : datapath reports all digits at zero
//   modo                        : current state encoding
//   inc_seg/inc_min_u/inc_min_d/inc_hora : 1-cycle increment strobes
//   dec_tick                    : 1-cycle decrement-one-second strobe
//   led_estado                  : adjust-mode indicator
//   alarme                      : countdown reached zero
module controle_cronometro
   import temporizador_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned TICK_DIV        = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       botao0,
   input  logic       botao1,
   input  logic       botao2,
   input  logic       SW3,
   input  logic       zero,
   output logic [2:0] modo,
   output logic       inc_seg,
   output logic       inc_min_u,
   output logic       inc_min_d,
   output logic       inc_hora,
   output logic       dec_tick,
   output logic [2:0] led_estado,
   output logic       alarme
);

   localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic p0, p1, p2;

   filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro0 (
      .clk(clk), .reset(reset), .bruto(botao0), .pulso(p0));
   filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro1 (
      .clk(clk), .reset(reset), .bruto(botao1), .pulso(p1));
   filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro2 (
      .clk(clk), .reset(reset), .bruto(botao2), .pulso(p2));

   estado_t          estado, estado_prox;
   logic [DIV_W-1:0] div, div_prox;
   logic             virada_c;
   estado_t          destino_c;
   logic             inc_seg_prox, inc_min_u_prox, inc_min_d_prox;
   logic             inc_hora_prox, dec_tick_prox;

   assign modo = estado;

   // State, divider and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado     <= PARADO;
         div        <= '0;
         inc_seg    <= 1'b0;
         inc_min_u  <= 1'b0;
         inc_min_d  <= 1'b0;
         inc_hora   <= 1'b0;
         dec_tick   <= 1'b0;
         led_estado <= LED_APAGADO;
         alarme     <= 1'b0;
      end else begin
         estado     <= estado_prox;
         div        <= div_prox;
         inc_seg    <= inc_seg_prox;
         inc_min_u  <= inc_min_u_prox;
         inc_min_d  <= inc_min_d_prox;
         inc_hora   <= inc_hora_prox;
         dec_tick   <= dec_tick_prox;
         led_estado <= led_de(estado_prox);
         alarme     <= (estado_prox == FIM);
      end
   end

   // Next state and strobes; p2 beats p0 beats p1, and a state change never
   // carries an increment strobe.
   always_comb begin
      estado_prox    = estado;
      inc_seg_prox   = 1'b0;
      inc_min_u_prox = 1'b0;
      inc_min_d_prox = 1'b0;
      inc_hora_prox  = 1'b0;
      dec_tick_prox  = 1'b0;
      virada_c       = (estado == RODANDO) && (div == DIV_W'(TICK_DIV - 1));
      destino_c      = zero ? PARADO : RODANDO;

      case (estado)
         PARADO: begin
            if (p2) begin
               if (!zero) estado_prox = RODANDO;
            end else if (p0) begin
               estado_prox = AJ_SEG;
            end
         end
         AJ_SEG: begin
            if (p2)      estado_prox  = destino_c;
            else if (p0) estado_prox  = AJ_MIN;
            else if (p1) inc_seg_prox = 1'b1;
         end
         AJ_MIN: begin
            if (p2)      estado_prox = destino_c;
            else if (p0) estado_prox = AJ_HORA;
            else if (p1) begin
               inc_min_d_prox = SW3;
               inc_min_u_prox = !SW3;
            end
         end
         AJ_HORA: begin
            if (p2 || p0) estado_prox   = destino_c;
            else if (p1)  inc_hora_prox = 1'b1;
         end
         RODANDO: begin
            if (p2) begin
               estado_prox = PARADO;
            end else if (virada_c) begin
               if (zero) estado_prox   = FIM;
               else      dec_tick_prox = 1'b1;
            end
         end
         FIM: begin
            if (p0 || p1 || p2) estado_prox = PARADO;
         end
         default: estado_prox = PARADO;
      endcase

      // Divider only runs while staying in RODANDO, so every entry restarts it.
      div_prox = '0;
      if ((estado == RODANDO) && (estado_prox == RODANDO) && !virada_c)
         div_prox = div + DIV_W'(1);
   end

endmodule

// File: tb/tb_controle_cronometro.sv
module tb_controle_cronometro;

   localparam int unsigned D = 4;
   localparam int unsigned T = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       botao0, botao1, botao2, SW3, zero;
   logic [2:0] modo, led_estado;
   logic       inc_seg, inc_min_u, inc_min_d, inc_hora, dec_tick, alarme;

   controle_cronometro #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
      .clk(clk), .reset(reset),
      .botao0(botao0), .botao1(botao1), .botao2(botao2),
      .SW3(SW3), .zero(zero),
      .modo(modo), .inc_seg(inc_seg), .inc_min_u(inc_min_u),
      .inc_min_d(inc_min_d), .inc_hora(inc_hora), .dec_tick(dec_tick),
      .led_estado(led_estado), .alarme(alarme));

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int c_seg, c_mu, c_md, c_h, c_dec;
   bit cmp_en = 1'b0;

   // ---------------- reference model ----------------
   localparam int M_PAR = 0, M_AJS = 1, M_AJM = 2, M_AJH = 3, M_FIM = 4, M_RUN = 7;

   int       m_modo, m_idade;
   bit [2:0] m_p, m_est, m_raw;
   bit [D+2:0] m_hist [3];
   bit       m_seg, m_mu, m_md, m_h, m_dec;
   bit [2:0] m_led;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_modo = M_PAR; m_idade = 0;
         m_p = '0; m_est = '0;
         for (int b = 0; b < 3; b++) m_hist[b] = '0;
         {m_seg, m_mu, m_md, m_h, m_dec} = '0;
      end else begin
         {m_seg, m_mu, m_md, m_h, m_dec} = '0;
         case (m_modo)
            M_RUN: begin
               m_idade++;
               if (m_p[2]) m_modo = M_PAR;
               else if (m_idade % T == 0) begin
                  if (zero) m_modo = M_FIM; else m_dec = 1'b1;
               end
            end
            M_FIM: if (m_p != 3'b000) m_modo = M_PAR;
            M_PAR: begin
               if (m_p[2]) begin
                  if (!zero) begin m_modo = M_RUN; m_idade = 0; end
               end else if (m_p[0]) m_modo = M_AJS;
            end
            default: begin
               if (m_p[2] || (m_p[0] && m_modo == M_AJH)) begin
                  if (zero) m_modo = M_PAR;
                  else begin m_modo = M_RUN; m_idade = 0; end
               end else if (m_p[0]) m_modo = m_modo + 1;
               else if (m_p[1]) begin
                  if (m_modo == M_AJS) m_seg = 1'b1;
                  else if (m_modo == M_AJH) m_h = 1'b1;
                  else if (SW3) m_md = 1'b1;
                  else m_mu = 1'b1;
               end
            end
         endcase
         // A level is accepted once D+1 consecutive synchronised samples differ.
         m_raw = {botao2, botao1, botao0};
         for (int b = 0; b < 3; b++) begin
            m_hist[b] = {m_hist[b][D+1:0], m_raw[b]};
            m_p[b] = 1'b0;
            if (&m_hist[b][D+2:2] && !m_est[b]) begin m_est[b] = 1'b1; m_p[b] = 1'b1; end
            else if (~|m_hist[b][D+2:2] && m_est[b]) m_est[b] = 1'b0;
         end
      end
      case (m_modo)
         M_AJS:   m_led = 3'b001;
         M_AJM:   m_led = 3'b011;
         M_AJH:   m_led = 3'b111;
         default: m_led = 3'b000;
      endcase
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nome, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
      end
   endtask

   task automatic ciclo();
      @(posedge clk); #1;
      c_seg += int'(inc_seg); c_mu += int'(inc_min_u); c_md += int'(inc_min_d);
      c_h += int'(inc_hora); c_dec += int'(dec_tick);
      if (cmp_en)
         chk("modelo", int'({modo, led_estado, alarme, inc_seg, inc_min_u, inc_min_d, inc_hora, dec_tick}),
             int'({3'(m_modo), m_led, (m_modo == M_FIM), m_seg, m_mu, m_md, m_h, m_dec}));
   endtask

   task automatic zera_cont();
      c_seg = 0; c_mu = 0; c_md = 0; c_h = 0; c_dec = 0;
   endtask

   task automatic aperta(input bit [2:0] m, input int hold, input int gap);
      {botao2, botao1, botao0} = m;
      repeat (hold) ciclo();
      {botao2, botao1, botao0} = 3'b000;
      repeat (gap) ciclo();
   endtask

   typedef struct {
      bit [2:0] btn; bit sw; bit z; int hold; int gap;
      bit [2:0] modo; bit [2:0] led; bit al;
      int seg; int mu; int md; int h; int dec;
   } vec_t;

   vec_t tab [16];

   initial begin
      tab[0]  = '{3'b010, 1'b0, 1'b0, 20, 10, 3'd1, 3'b001, 1'b0, 1, 0, 0, 0, 0};
      tab[1]  = '{3'b010, 1'b0, 1'b0,  3, 10, 3'd1, 3'b001, 1'b0, 0, 0, 0, 0, 0};
      tab[2]  = '{3'b001, 1'b0, 1'b0, 20, 10, 3'd2, 3'b011, 1'b0, 0, 0, 0, 0, 0};
      tab[3]  = '{3'b010, 1'b0, 1'b0, 20, 10, 3'd2, 3'b011, 1'b0, 0, 1, 0, 0, 0};
      tab[4]  = '{3'b010, 1'b1, 1'b0, 20, 10, 3'd2, 3'b011, 1'b0, 0, 0, 1, 0, 0};
      tab[5]  = '{3'b010, 1'b0, 1'b0,  3, 10, 3'd2, 3'b011, 1'b0, 0, 0, 0, 0, 0};
      tab[6]  = '{3'b001, 1'b0, 1'b0, 20, 10, 3'd3, 3'b111, 1'b0, 0, 0, 0, 0, 0};
      tab[7]  = '{3'b010, 1'b0, 1'b0, 20, 10, 3'd3, 3'b111, 1'b0, 0, 0, 0, 1, 0};
      tab[8]  = '{3'b001, 1'b0, 1'b1, 20, 10, 3'd0, 3'b000, 1'b0, 0, 0, 0, 0, 0};
      tab[9]  = '{3'b100, 1'b0, 1'b1, 20, 10, 3'd0, 3'b000, 1'b0, 0, 0, 0, 0, 0};
      tab[10] = '{3'b001, 1'b0, 1'b1, 20, 10, 3'd1, 3'b001, 1'b0, 0, 0, 0, 0, 0};
      tab[11] = '{3'b100, 1'b0, 1'b0, 20, 15, 3'd7, 3'b000, 1'b0, 0, 0, 0, 0, 2};
      tab[12] = '{3'b100, 1'b0, 1'b0, 20, 10, 3'd0, 3'b000, 1'b0, 0, 0, 0, 0, 1};
      tab[13] = '{3'b001, 1'b0, 1'b0, 20, 10, 3'd1, 3'b001, 1'b0, 0, 0, 0, 0, 0};
      tab[14] = '{3'b100, 1'b0, 1'b0, 20, 10, 3'd7, 3'b000, 1'b0, 0, 0, 0, 0, 2};
      tab[15] = '{3'b100, 1'b0, 1'b0, 20, 10, 3'd0, 3'b000, 1'b0, 0, 0, 0, 0, 0};

      // Reset values
      reset = 1'b0; {botao2, botao1, botao0} = 3'b000; SW3 = 1'b0; zero = 1'b0;
      zera_cont();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_modo", int'(modo), 0);
      chk("reset_led", int'(led_estado), 0);
      chk("reset_alarme", int'(alarme), 0);
      chk("reset_strobes", int'({inc_seg, inc_min_u, inc_min_d, inc_hora, dec_tick}), 0);
      #3 reset = 1'b1;

      // Debounce latency: state changes 8 edges after the raw rise
      ciclo();
      botao0 = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         if (j == 21) botao0 = 1'b0;
         ciclo();
         if (j == 7) chk("lat_modo_antes", int'(modo), 0);
         if (j == 8) begin
            chk("lat_modo", int'(modo), 1);
            chk("lat_led", int'(led_estado), 1);
         end
      end

      // Table-driven button steps
      for (int i = 0; i < 16; i++) begin
         SW3 = tab[i].sw; zero = tab[i].z;
         zera_cont();
         aperta(tab[i].btn, tab[i].hold, tab[i].gap);
         chk($sformatf("tab%0d_modo", i), int'(modo), int'(tab[i].modo));
         chk($sformatf("tab%0d_led", i), int'(led_estado), int'(tab[i].led));
         chk($sformatf("tab%0d_alarme", i), int'(alarme), int'(tab[i].al));
         chk($sformatf("tab%0d_seg", i), c_seg, tab[i].seg);
         chk($sformatf("tab%0d_min_u", i), c_mu, tab[i].mu);
         chk($sformatf("tab%0d_min_d", i), c_md, tab[i].md);
         chk($sformatf("tab%0d_hora", i), c_h, tab[i].h);
         chk($sformatf("tab%0d_dec", i), c_dec, tab[i].dec);
      end

      // Run and expire
      SW3 = 1'b0; zero = 1'b0;
      botao2 = 1'b1;
      for (int j = 1; j <= 38; j++) begin
         if (j == 21) botao2 = 1'b0;
         ciclo();
         if (j == 7) chk("run_modo_antes", int'(modo), 0);
         if (j == 8) chk("run_modo", int'(modo), 7);
         chk($sformatf("run_dec_%0d", j), int'(dec_tick), int'(j == 18 || j == 28));
         if (j == 28) zero = 1'b1;
         if (j == 37) chk("run_modo_pre_fim", int'(modo), 7);
      end
      chk("fim_modo", int'(modo), 4);
      chk("fim_alarme", int'(alarme), 1);
      zera_cont();
      aperta(3'b010, 20, 10);
      chk("fim_sai_modo", int'(modo), 0);
      chk("fim_sai_alarme", int'(alarme), 0);
      chk("fim_sai_strobes", c_seg + c_mu + c_md + c_h + c_dec, 0);

      // Simultaneous increment and start/stop in AJ_SEG
      zero = 1'b0;
      aperta(3'b001, 20, 10);
      chk("sim_pre_modo", int'(modo), 1);
      zera_cont();
      aperta(3'b110, 20, 10);
      chk("sim_modo", int'(modo), 7);
      chk("sim_inc_seg", c_seg, 0);
      aperta(3'b100, 20, 10);
      chk("sim_para", int'(modo), 0);

      // Reset mid-run
      botao2 = 1'b1;
      repeat (8) ciclo();
      chk("rst_run_modo", int'(modo), 7);
      repeat (5) ciclo();
      botao2 = 1'b0;
      #3 reset = 1'b0;
      #1;
      chk("rst_async_modo", int'(modo), 0);
      chk("rst_async_dec", int'(dec_tick), 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      zera_cont();
      repeat (30) ciclo();
      chk("rst_pos_dec", c_dec, 0);
      chk("rst_pos_modo", int'(modo), 0);

      // Randomised stimulus against the reference model
      cmp_en = 1'b1;
      for (int e = 0; e < 70; e++) begin
         int hold;
         SW3 = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) zero = ~zero;
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(6, 25));
         if (e == 35) begin
            #3 reset = 1'b0;
            @(posedge clk);
            #4 reset = 1'b1;
         end
         aperta(3'($urandom_range(0, 7)), hold, int'($urandom_range(0, 12)));
      end
      cmp_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
